// File: rtl/filter_storage_reader.sv
// filter_storage_reader
//   Streams a burst of words out of a synchronous-read filter storage.
//   A burst is requested with a one-cycle start pulse (base_addr, len). Reads
//   are issued only while the 2-entry output buffer plus the in-flight read
//   leave room, so a stalled consumer never loses data. Words go out on a
//   valid/ready stream with out_last on the final word.
//
// Ports
//   clk, rstb            clock, synchronous active-high reset
//   start, base_addr,len burst request (taken in IDLE only, len 0..2^AW)
//   rden, rdptr, rddata  storage read port (rddata valid 1 cycle after rden)
//   out_valid/ready/data/last  output stream
//   busy, done, err      status (done/err are one-cycle pulses)
//
// Configuration
//   FILTER_READER_WRAP_EN  defined: addresses wrap modulo 2^AW, err never set.
//                          undefined: a burst running past the top address is
//                          clipped at 2^AW-1 and err pulses with done.
module filter_storage_reader #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          rden,
    output logic [AW-1:0] rdptr,
    input  logic [DW-1:0] rddata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t        r_state;
    logic [AW-1:0] r_base;
    logic [AW:0]   r_len;
    logic [AW:0]   r_issued;
    logic [AW:0]   r_deliv;
    logic          r_clip;
    logic          r_inflight;
    logic          r_zdone;
    logic [DW-1:0] r_buf [2];
    logic          r_wp;
    logic          r_rp;
    logic [1:0]    r_cnt;

    logic          w_empty;
    logic          w_fire;
    logic          w_push;
    logic          w_pop;
    logic          w_fin;
    logic [AW:0]   w_len_eff;
    logic          w_clip;

`ifdef FILTER_READER_WRAP_EN
    assign w_len_eff = len;
    assign w_clip    = 1'b0;
`else
    localparam logic [AW+1:0] DEPTH = (AW+2)'(1) << AW;
    logic [AW+1:0] w_end;
    // One extra bit so base+len up to 2*2^AW cannot overflow the compare.
    assign w_end     = {2'b00, base_addr} + {1'b0, len};
    assign w_clip    = (w_end > DEPTH);
    assign w_len_eff = w_clip ? (DEPTH[AW:0] - {1'b0, base_addr}) : len;
`endif

    assign w_empty = (r_cnt == 2'd0);

    // Occupancy gate: buffered words + outstanding read must stay below 2,
    // which guarantees the returning word always has a buffer slot.
    assign rden  = (r_state == S_RUN) && (r_issued != r_len) &&
                   (({1'b0, r_cnt} + {2'b00, r_inflight}) < 3'd2);
    assign rdptr = r_base + r_issued[AW-1:0];

    // Fall-through: a returning word is presented the same cycle it arrives
    // when the buffer is empty; it only lands in the buffer if not taken.
    assign out_valid = !w_empty || r_inflight;
    assign out_data  = !w_empty   ? r_buf[r_rp] :
                       r_inflight ? rddata      : '0;
    assign out_last  = out_valid && (r_deliv == r_len - 1'b1);

    assign w_fire = out_valid && out_ready;
    assign w_pop  = w_fire && !w_empty;
    assign w_push = r_inflight && !(w_empty && out_ready);
    assign w_fin  = (r_state == S_DRAIN) && w_empty && !r_inflight;

    assign busy = (r_state != S_IDLE);
    assign done = r_zdone || w_fin;
    assign err  = w_fin && r_clip;

    always_ff @(posedge clk) begin
        if (rstb) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_deliv    <= '0;
            r_clip     <= 1'b0;
            r_inflight <= 1'b0;
            r_zdone    <= 1'b0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            r_zdone    <= 1'b0;
            r_inflight <= rden;
            if (w_push) begin
                r_buf[r_wp] <= rddata;
                r_wp        <= ~r_wp;
            end
            if (w_pop)
                r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_fire)
                r_deliv <= r_deliv + 1'b1;
            if (rden)
                r_issued <= r_issued + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            r_zdone <= 1'b1;
                        end else begin
                            r_base   <= base_addr;
                            r_len    <= w_len_eff;
                            r_clip   <= w_clip;
                            r_issued <= '0;
                            r_deliv  <= '0;
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (rden && (r_issued + 1'b1 == r_len))
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_fin)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_filter_storage_reader.sv
// Bench for filter_storage_reader: storage model answering reads, a
// transaction-level reference (expected address list / word list per burst)
// compared every cycle, a few literal directed cases, then random bursts.
module tb_filter_storage_reader;
    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rstb = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          rden;
    logic [AW-1:0] rdptr;
    logic [DW-1:0] rddata = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    filter_storage_reader #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rstb(rstb), .start(start), .base_addr(base_addr), .len(len),
        .rden(rden), .rdptr(rdptr), .rddata(rddata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- storage model ----------------
    logic [DW-1:0] mem [0:511];
    logic          pend_en = 1'b0;
    logic [AW-1:0] pend_a = '0;
    always @(negedge clk) begin
        pend_en = rden;
        pend_a  = rdptr;
    end
    always @(posedge clk) begin
        #1;
        rddata = pend_en ? mem[pend_a] : DW'($urandom);
    end

    // ---------------- ready generator ----------------
    bit rdy_rand = 1'b0;
    bit rdy_force = 1'b1;
    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    // ---------------- reference model + compare ----------------
    logic rst_seen = 1'b0;
    always @(posedge clk) rst_seen <= rstb;

    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    bit            started = 1'b0;
    bit            busy_m = 1'b0, clip_m = 1'b0;
    bit            done_nx = 1'b0, err_nx = 1'b0, done_m, err_m;
    int            issued_m = 0, deliv_m = 0;
    bit            stall_p = 1'b0;
    logic [DW-1:0] data_p;
    logic          last_p;
    bit            b_now;
    int            n_words, a_i;

    always @(negedge clk) begin
        if (rst_seen) begin
            chk("rst_rden", rden, 0);
            chk("rst_rdptr", rdptr, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_last", out_last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            exp_addr_q.delete();
            exp_data_q.delete();
            busy_m = 0; done_nx = 0; err_nx = 0; stall_p = 0;
            issued_m = 0; deliv_m = 0;
            started = 1'b1;
        end else if (started) begin
            done_m = done_nx; err_m = err_nx;
            done_nx = 0; err_nx = 0;
            b_now = busy_m;
            chk("done", done, done_m);
            chk("err", err, done_m && err_m);
            chk("busy", busy, busy_m);
            if (stall_p) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, data_p);
                chk("hold_last", out_last, last_p);
            end
            if (rden) begin
                if (exp_addr_q.size() == 0) chk("extra_read", 1, 0);
                else chk("rdptr", rdptr, exp_addr_q.pop_front());
                chk("read_window", (issued_m - deliv_m) < 2, 1);
                issued_m++;
            end
            if (out_last && !out_valid) chk("last_wo_valid", 1, 0);
            if (out_valid && out_ready) begin
                if (exp_data_q.size() == 0) chk("extra_word", 1, 0);
                else begin
                    chk("out_data", out_data, exp_data_q[0]);
                    chk("out_last", out_last, exp_data_q.size() == 1);
                    void'(exp_data_q.pop_front());
                    deliv_m++;
                    if (exp_data_q.size() == 0) begin
                        done_nx = 1; err_nx = clip_m;
                    end
                end
            end
            stall_p = out_valid && !out_ready;
            data_p  = out_data;
            last_p  = out_last;
            if (done_m) busy_m = 0;
            if (start && !b_now) begin
                n_words = int'(len);
                clip_m  = 0;
`ifndef FILTER_READER_WRAP_EN
                if (int'(base_addr) + int'(len) > 512) begin
                    clip_m  = 1;
                    n_words = 512 - int'(base_addr);
                end
`endif
                if (n_words == 0) begin
                    done_nx = 1; err_nx = 0;
                end else begin
                    busy_m = 1; issued_m = 0; deliv_m = 0;
                    for (int i = 0; i < n_words; i++) begin
                        a_i = (int'(base_addr) + i) % 512;
                        exp_addr_q.push_back(AW'(a_i));
                        exp_data_q.push_back(mem[a_i]);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
        start = 1'b1; base_addr = b; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit spam, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
            @(posedge clk); #1;
            start     = spam && ($urandom_range(0, 5) == 0);
            base_addr = AW'($urandom);
            len       = (AW+1)'($urandom_range(0, 30));
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
    endtask

    logic [DW-1:0] lit [4];
    logic [AW-1:0] addrs [8];
    int            nrd, sel;
    bit            got, err_seen;
    logic [AW-1:0] ba;
    logic [AW:0]   ln;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = DW'($urandom);
        lit[0] = 16'h1234; lit[1] = 16'hBEEF; lit[2] = 16'h0F0F; lit[3] = 16'h8001;
        for (int i = 0; i < 4; i++) mem[i] = lit[i];

        repeat (3) @(posedge clk);
        #1 rstb = 1'b0;
        @(posedge clk); #1;

        // base 0, len 4, ready high: fixed cycle-by-cycle picture
        do_start(9'd0, 10'd4);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("d1_rden", rden, c <= 4);
            if (c <= 4) chk("d1_rdptr", rdptr, c - 1);
            chk("d1_valid", out_valid, c >= 2 && c <= 5);
            if (c >= 2 && c <= 5) chk("d1_data", out_data, lit[c-2]);
            chk("d1_last", out_last, c == 5);
            chk("d1_done", done, c == 6);
            chk("d1_busy", busy, c <= 6);
        end
        @(posedge clk); #1;

        // len 3 with consumer stalled for 10 cycles
        rdy_force = 1'b0;
        do_start(9'd100, 10'd3);
        nrd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rden) nrd++;
            if (c == 9) begin
                @(posedge clk); #1;
                rdy_force = 1'b1;
            end
        end
        chk("d2_stall_reads", nrd, 2);
        wait_done(50, 1'b0, got);

        // burst crossing the top address
        do_start(9'd510, 10'd4);
        nrd = 0; err_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rden && nrd < 8) begin addrs[nrd] = rdptr; nrd++; end
            if (done) begin err_seen = err; break; end
        end
        @(posedge clk); #1;
`ifdef FILTER_READER_WRAP_EN
        chk("d3_nreads", nrd, 4);
        chk("d3_a2", addrs[2], 0);
        chk("d3_a3", addrs[3], 1);
        chk("d3_err", err_seen, 0);
`else
        chk("d3_nreads", nrd, 2);
        chk("d3_err", err_seen, 1);
`endif
        chk("d3_a0", addrs[0], 510);
        chk("d3_a1", addrs[1], 511);

        // zero-length request
        do_start(9'd7, 10'd0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("d4_done", done, c == 1);
            chk("d4_rden", rden, 0);
            chk("d4_busy", busy, 0);
        end
        @(posedge clk); #1;

        // start while busy is ignored
        do_start(9'd20, 10'd8);
        repeat (2) @(posedge clk);
        #1 start = 1'b1; base_addr = 9'd300; len = 10'd5;
        @(posedge clk); #1 start = 1'b0;
        wait_done(100, 1'b0, got);

        // reset in the middle of a burst
        do_start(9'd40, 10'd10);
        repeat (3) @(posedge clk);
        #1 rstb = 1'b1;
        @(posedge clk); #1 rstb = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            chk("d5_no_done", done, 0);
            chk("d5_idle", busy, 0);
        end
        @(posedge clk); #1;

        // random bursts
        for (int b = 0; b < 40; b++) begin
            rdy_rand  = ($urandom_range(0, 3) != 0);
            rdy_force = 1'b1;
            sel = $urandom_range(0, 9);
            ba  = AW'($urandom);
            if (sel < 6)       ln = (AW+1)'($urandom_range(1, 24));
            else if (sel < 8) begin
                ba = AW'($urandom_range(490, 511));
                ln = (AW+1)'($urandom_range(1, 40));
            end
            else if (sel == 8) ln = '0;
            else               ln = (AW+1)'($urandom_range(400, 512));
            do_start(ba, ln);
            wait_done(4000, 1'b1, got);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rdy_rand = 1'b0;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
